// File: rtl/state_pkg.sv
// Shared types and constants for the gate arbiter and the upstream gate-span comparators.
package state_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        HOLD    = 3'd3,
        CLOSING = 3'd4
    } GateState;

    localparam logic [9:0] GATE_X_MIN = 10'd310;
    localparam logic [9:0] GATE_X_MAX = 10'd450;

    // Used by the player controllers to derive in_gate_pN from their x position.
    function automatic logic x_in_gate(input logic [9:0] x);
        return (x >= GATE_X_MIN) && (x <= GATE_X_MAX);
    endfunction

endpackage

// File: rtl/vtick_edge.sv
// Rising-edge detector on the frame strobe: one-clk step pulse per new frame.
// A strobe already high when reset is released does not count as a step.
module vtick_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic v_tick,
    output logic step
);

    logic v_tick_old_q, v_tick_old_d;
    logic armed_q, armed_d;

    always_comb begin
        v_tick_old_d = v_tick;
        // Arm only after the strobe has been seen low, so a level held across reset is ignored.
        armed_d      = armed_q | ~v_tick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_tick_old_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            v_tick_old_q <= v_tick_old_d;
            armed_q      <= armed_d;
        end
    end

    assign step = v_tick & ~v_tick_old_q & armed_q;

endmodule

// File: rtl/gate_arbiter_ctl.sv
// Round-robin gate arbiter and open/hold/close sequencer, stepped once per frame.
// Define GATE_SAFETY_REOPEN_EN to reopen a closing gate when a player is inside it.
module gate_arbiter_ctl
    import state_pkg::*;
#(
    parameter int OPEN_STEPS  = 32,
    parameter int HOLD_FRAMES = 120
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              v_tick,
    input  logic                              req_p1,
    input  logic                              req_p2,
    input  logic                              in_gate_p1,
    input  logic                              in_gate_p2,
    output logic [1:0]                        grant,
    output logic [$clog2(OPEN_STEPS+1)-1:0]   gate_level,
    output logic                              pass_ok,
    output GateState                          gate_state
);

    localparam int LVL_W = $clog2(OPEN_STEPS + 1);
    localparam int TMR_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(OPEN_STEPS);
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(HOLD_FRAMES);

    logic step;

    vtick_edge u_vtick_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .v_tick (v_tick),
        .step   (step)
    );

    GateState         state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       grant_q, grant_d;
    logic             pass_ok_q, pass_ok_d;
    // Set when P2 owned the gate last, so P1 wins a simultaneous request.
    logic             rr_last_p2_q, rr_last_p2_d;

    logic granted_req;
    logic any_in_gate;
    logic reopen;

    assign granted_req = (grant_q[0] & req_p1) | (grant_q[1] & req_p2);
    assign any_in_gate = in_gate_p1 | in_gate_p2;

`ifdef GATE_SAFETY_REOPEN_EN
    assign reopen = any_in_gate;
`else
    assign reopen = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        timer_d      = timer_q;
        grant_d      = grant_q;
        rr_last_p2_d = rr_last_p2_q;

        if (step) begin
            case (state_q)
                CLOSED: begin
                    if (req_p1 && req_p2) begin
                        grant_d = rr_last_p2_q ? 2'b01 : 2'b10;
                    end else if (req_p1) begin
                        grant_d = 2'b01;
                    end else if (req_p2) begin
                        grant_d = 2'b10;
                    end
                    if (req_p1 || req_p2) begin
                        state_d = OPENING;
                    end
                end
                OPENING: begin
                    if (!granted_req && !any_in_gate) begin
                        state_d = CLOSING;
                    end else if (level_q >= LVL_MAX - LVL_W'(1)) begin
                        level_d = LVL_MAX;
                        state_d = OPEN;
                    end else begin
                        level_d = level_q + LVL_W'(1);
                    end
                end
                OPEN: begin
                    if (!granted_req) begin
                        state_d = HOLD;
                        timer_d = TMR_INIT;
                    end
                end
                HOLD: begin
                    if (granted_req) begin
                        state_d = OPEN;
                    end else if (timer_q == '0) begin
                        // An occupied gate keeps holding with the timer parked at 0.
                        if (!any_in_gate) begin
                            state_d = CLOSING;
                        end
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                CLOSING: begin
                    if (reopen) begin
                        state_d = OPENING;
                    end else if (level_q <= LVL_W'(1)) begin
                        level_d      = '0;
                        state_d      = CLOSED;
                        grant_d      = 2'b00;
                        rr_last_p2_d = grant_q[1];
                    end else begin
                        level_d = level_q - LVL_W'(1);
                    end
                end
                default: begin
                    state_d = CLOSED;
                    level_d = '0;
                    grant_d = 2'b00;
                end
            endcase
        end

        pass_ok_d = (state_d == OPEN) || (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLOSED;
            level_q      <= '0;
            timer_q      <= '0;
            grant_q      <= 2'b00;
            pass_ok_q    <= 1'b0;
            rr_last_p2_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            pass_ok_q    <= pass_ok_d;
            rr_last_p2_q <= rr_last_p2_d;
        end
    end

    assign grant      = grant_q;
    assign gate_level = level_q;
    assign pass_ok    = pass_ok_q;
    assign gate_state = state_q;

endmodule

// File: tb/tb_gate_arbiter_ctl.sv
// Directed bench for gate_arbiter_ctl: a table of multi-step vectors plus hand-written corner sequences.
module tb_gate_arbiter_ctl;
    import state_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       v_tick;
    logic       req_p1, req_p2;
    logic       in_gate_p1, in_gate_p2;
    logic [1:0] grant;
    logic [5:0] gate_level;
    logic       pass_ok;
    GateState   gate_state;

    int tests_run;
    int tests_failed;

    gate_arbiter_ctl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_tick     (v_tick),
        .req_p1     (req_p1),
        .req_p2     (req_p2),
        .in_gate_p1 (in_gate_p1),
        .in_gate_p2 (in_gate_p2),
        .grant      (grant),
        .gate_level (gate_level),
        .pass_ok    (pass_ok),
        .gate_state (gate_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       p1;
        logic       p2;
        logic       g1;
        logic       g2;
        logic [1:0] grant;
        int         level;
        logic       pass;
        GateState   st;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] g, input int lvl,
                             input logic p, input GateState st);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".level"}, 32'(gate_level), 32'(lvl));
        check({tag, ".pass_ok"}, 32'(pass_ok), 32'(p));
        check({tag, ".state"}, 32'(gate_state), 32'(st));
    endtask

    // One frame: strobe high for one clock, low for two; outputs sampled on a falling edge.
    task automatic do_step();
        @(negedge clk) v_tick = 1'b1;
        @(negedge clk) v_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        v_tick = 1'b0;
        req_p1 = 1'b0; req_p2 = 1'b0;
        in_gate_p1 = 1'b0; in_gate_p2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int steps_to_close;
        tests_run    = 0;
        tests_failed = 0;
        rst_n  = 1'b0;
        v_tick = 1'b0;
        req_p1 = 1'b0; req_p2 = 1'b0;
        in_gate_p1 = 1'b0; in_gate_p2 = 1'b0;

        //           n    p1 p2 g1 g2 grant  lvl pass state
        vecs[0]  = '{1,   1, 0, 0, 0, 2'b01, 0,  0,   OPENING};
        vecs[1]  = '{31,  1, 0, 0, 0, 2'b01, 31, 0,   OPENING};
        vecs[2]  = '{1,   1, 0, 0, 0, 2'b01, 32, 1,   OPEN};
        vecs[3]  = '{7,   1, 1, 0, 0, 2'b01, 32, 1,   OPEN};
        vecs[4]  = '{1,   0, 1, 0, 0, 2'b01, 32, 1,   HOLD};
        vecs[5]  = '{1,   1, 0, 0, 0, 2'b01, 32, 1,   OPEN};
        vecs[6]  = '{1,   0, 0, 0, 0, 2'b01, 32, 1,   HOLD};
        vecs[7]  = '{120, 0, 0, 0, 0, 2'b01, 32, 1,   HOLD};
        vecs[8]  = '{1,   0, 0, 0, 1, 2'b01, 32, 1,   HOLD};
        vecs[9]  = '{1,   0, 0, 0, 1, 2'b01, 32, 1,   HOLD};
        vecs[10] = '{1,   0, 0, 0, 0, 2'b01, 32, 0,   CLOSING};
        vecs[11] = '{12,  0, 0, 0, 0, 2'b01, 20, 0,   CLOSING};

        do_reset();
        check_all("reset", 2'b00, 0, 1'b0, CLOSED);

        for (int i = 0; i < 12; i++) begin
            req_p1 = vecs[i].p1; req_p2 = vecs[i].p2;
            in_gate_p1 = vecs[i].g1; in_gate_p2 = vecs[i].g2;
            for (int s = 0; s < vecs[i].n; s++) do_step();
            $display("[TB] vec %0d: %0d steps -> grant=%b level=%0d pass=%b state=%0d",
                     i, vecs[i].n, grant, gate_level, pass_ok, gate_state);
            check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].level, vecs[i].pass, vecs[i].st);
        end

        // Player walks into the gate while it is closing from level 20.
        in_gate_p1 = 1'b1;
        do_step();
`ifdef GATE_SAFETY_REOPEN_EN
        check_all("safety1", 2'b01, 20, 1'b0, OPENING);
`else
        check_all("safety1", 2'b01, 19, 1'b0, CLOSING);
`endif
        do_step();
`ifdef GATE_SAFETY_REOPEN_EN
        check_all("safety2", 2'b01, 21, 1'b0, OPENING);
`else
        check_all("safety2", 2'b01, 18, 1'b0, CLOSING);
`endif
        in_gate_p1 = 1'b0;
        steps_to_close = 0;
        while (gate_state != CLOSED && steps_to_close < 60) begin
            do_step();
            steps_to_close++;
        end
`ifdef GATE_SAFETY_REOPEN_EN
        check("close_steps", 32'(steps_to_close), 32'd22);
`else
        check("close_steps", 32'(steps_to_close), 32'd18);
`endif
        $display("[TB] close sequence: %0d steps to CLOSED", steps_to_close);
        check_all("closed", 2'b00, 0, 1'b0, CLOSED);

        // Round-robin arbitration.
        do_reset();
        req_p1 = 1'b1; req_p2 = 1'b1;
        do_step();
        check("rr1.grant", 32'(grant), 32'(2'b01));
        req_p1 = 1'b0; req_p2 = 1'b0;
        do_step();
        check_all("rr1.drop", 2'b01, 0, 1'b0, CLOSING);
        do_step();
        check_all("rr1.closed", 2'b00, 0, 1'b0, CLOSED);
        req_p1 = 1'b1; req_p2 = 1'b1;
        do_step();
        check("rr2.grant", 32'(grant), 32'(2'b10));
        req_p1 = 1'b0; req_p2 = 1'b0;
        do_step(); do_step();
        check("rr2.closed", 32'(gate_state), 32'(CLOSED));
        req_p1 = 1'b1; req_p2 = 1'b1;
        do_step();
        check("rr3.grant", 32'(grant), 32'(2'b01));
        $display("[TB] round-robin sequence done: grant=%b", grant);

        // P2 held through P1's close is granted on the step after CLOSED.
        req_p1 = 1'b0;
        do_step();
        check_all("held.closing", 2'b01, 0, 1'b0, CLOSING);
        do_step();
        check_all("held.closed", 2'b00, 0, 1'b0, CLOSED);
        do_step();
        check_all("held.grant", 2'b10, 0, 1'b0, OPENING);

        // Asynchronous reset mid-OPENING, with v_tick held high across it.
        do_reset();
        req_p1 = 1'b1;
        for (int s = 0; s < 11; s++) do_step();
        check_all("pre_rst", 2'b01, 10, 1'b0, OPENING);
        #2 rst_n = 1'b0;
        v_tick = 1'b1;
        #1;
        check_all("async_rst", 2'b00, 0, 1'b0, CLOSED);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all("vtick_held", 2'b00, 0, 1'b0, CLOSED);
        v_tick = 1'b0;
        @(negedge clk);
        do_step();
        check_all("post_rst", 2'b01, 0, 1'b0, OPENING);
        $display("[TB] reset sequence done: grant=%b state=%0d", grant, gate_state);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
